// File: rtl/mcu_pkg.sv
// Shared types and constants for the MCU byte dispatcher and its targets.
// Holds the FSM state enum, well-known target ids and the status-byte table.
package mcu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_FORWARD,
    ST_STATUS,
    ST_DISCARD
  } state_t;

  localparam logic [7:0] STATUS_ID_DEF = 8'hFF;
  localparam logic [7:0] SIGNATURE     = 8'hD5;

  localparam logic [7:0] TGT_SYS = 8'd0;
  localparam logic [7:0] TGT_HID = 8'd1;
  localparam logic [7:0] TGT_OSD = 8'd2;
  localparam logic [7:0] TGT_SDC = 8'd3;

  // Byte the dispatcher's own status target returns at a given frame position.
  function automatic logic [7:0] status_byte(input logic [3:0] idx,
                                             input logic [7:0] irq,
                                             input logic [7:0] ntgt);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd1:    b = irq;
      4'd2:    b = ntgt;
      4'd3:    b = SIGNATURE;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mcu_dispatch.sv
// Routes MCU frames to a target picked by the first byte; 1 clk forward/return latency.
// No backpressure: every mcu_strobe byte is consumed, targets must accept one byte per strobe.
module mcu_dispatch
  import mcu_pkg::*;
#(
  parameter int         NUM_TARGETS = 4,
  parameter logic [7:0] STATUS_ID   = STATUS_ID_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mcu_strobe,
  input  logic                     mcu_start,
  input  logic [7:0]               mcu_din,
  output logic [7:0]               mcu_dout,
  output logic [NUM_TARGETS-1:0]   tgt_strobe,
  output logic                     tgt_start,
  output logic [7:0]               tgt_din,
  input  logic [8*NUM_TARGETS-1:0] tgt_dout,
  input  logic [NUM_TARGETS-1:0]   int_in,
  output logic                     int_out_n,
  output logic                     frame_active
);

  state_t                   state, state_nxt;
  logic [7:0]               sel, sel_nxt;
  logic [3:0]               byte_idx, idx_nxt;
  logic [NUM_TARGETS-1:0]   strobe_nxt;
  logic                     start_nxt;
  logic [7:0]               din_nxt;
  logic [7:0]               dout_nxt;
  logic [7:0]               fwd_byte;

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    idx_nxt    = byte_idx;
    strobe_nxt = '0;
    start_nxt  = 1'b0;
    din_nxt    = tgt_din;

    // A start byte wins in every state, so an interrupted frame is simply dropped.
    if (mcu_strobe && mcu_start) begin
      sel_nxt   = mcu_din;
      state_nxt = ST_SELECT;
      idx_nxt   = 4'd0;
    end else if (mcu_strobe) begin
      case (state)
        ST_SELECT: begin
          if (int'(sel) < NUM_TARGETS) begin
            for (int i = 0; i < NUM_TARGETS; i++) strobe_nxt[i] = (sel == 8'(i));
            start_nxt = 1'b1;
            din_nxt   = mcu_din;
            state_nxt = ST_FORWARD;
          end else if (sel == STATUS_ID) begin
            state_nxt = ST_STATUS;
            idx_nxt   = 4'd1;
          end else begin
            state_nxt = ST_DISCARD;
          end
        end
        ST_FORWARD: begin
          for (int i = 0; i < NUM_TARGETS; i++) strobe_nxt[i] = (sel == 8'(i));
          din_nxt = mcu_din;
        end
        ST_STATUS: begin
          if (byte_idx != 4'd15) idx_nxt = byte_idx + 4'd1;
        end
        default: ;
      endcase
    end

    fwd_byte = 8'h00;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (sel_nxt == 8'(i)) fwd_byte = tgt_dout[8*i +: 8];
    end

    case (state_nxt)
      ST_FORWARD: dout_nxt = fwd_byte;
      ST_STATUS:  dout_nxt = status_byte(idx_nxt, 8'(int_in), 8'(NUM_TARGETS));
      default:    dout_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sel        <= 8'h00;
      byte_idx   <= 4'd0;
      tgt_strobe <= '0;
      tgt_start  <= 1'b0;
      tgt_din    <= 8'h00;
      mcu_dout   <= 8'h00;
      int_out_n  <= 1'b1;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      byte_idx   <= idx_nxt;
      tgt_strobe <= strobe_nxt;
      tgt_start  <= start_nxt;
      tgt_din    <= din_nxt;
      mcu_dout   <= dout_nxt;
      int_out_n  <= ~|int_in;
    end
  end

  assign frame_active = (state == ST_FORWARD) || (state == ST_STATUS);

endmodule
